// File: rtl/regbank_pkg.sv
// Shared constants and types for the MIPS register bank and the write-register selector.
package regbank_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_RA   = 31;
    localparam int unsigned SP_RESET = 227;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [REG_DATA_W-1:0] word_t;

endpackage

// File: rtl/reg_read_port.sv
// One registered read port: zero/bypass mux feeding a load-enabled operand register.
module reg_read_port
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] row_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              load_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] value_d;
    logic [DATA_W-1:0] data_q;

    // Index 0 reads zero even when it is being written; otherwise write-first bypass.
    always_comb begin
        value_d = row_i;
        if (raddr_i == ADDR_W'(REG_ZERO)) begin
            value_d = '0;
        end else if (we_i && (waddr_i == raddr_i)) begin
            value_d = wdata_i;
        end
    end

    // Operand register, captured only when load is asserted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= value_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/register_bank.sv
// 32 x 32-bit register file with one write port and two registered read ports.
module register_bank
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned SP_INDEX = REG_SP,
    parameter int unsigned SP_RESET = regbank_pkg::SP_RESET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic              load_ab,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic              wr_en;

    // Index 0 is never written, so it keeps its reset value of zero.
    assign wr_en = reg_write && (write_reg != ADDR_W'(REG_ZERO));

    // Register array: reset loads $sp, otherwise one write per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (wr_en) begin
            regs_q[write_reg] <= write_data;
        end
    end

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .clk_i   (clk),
        .rst_i   (reset),
        .row_i   (regs_q[read_reg1]),
        .we_i    (reg_write),
        .waddr_i (write_reg),
        .wdata_i (write_data),
        .raddr_i (read_reg1),
        .load_i  (load_ab),
        .data_o  (read_data1)
    );

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .clk_i   (clk),
        .rst_i   (reset),
        .row_i   (regs_q[read_reg2]),
        .we_i    (reg_write),
        .waddr_i (write_reg),
        .wdata_i (write_data),
        .raddr_i (read_reg2),
        .load_i  (load_ab),
        .data_o  (read_data2)
    );

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: stimulus pushes expected operands, a monitor checks them.
module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        load_ab;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [32];
    logic [63:0] exp_q [$];

    register_bank dut (
        .clk        (clk),
        .reset      (reset),
        .reg_write  (reg_write),
        .write_reg  (write_reg),
        .write_data (write_data),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .load_ab    (load_ab),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[29] = 32'd227;
    endtask

    function automatic logic [31:0] model_val(input logic [4:0] idx, input logic we,
                                              input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'h0;
        if (we && wr == idx) return wd;
        return model[idx];
    endfunction

    // Drive one cycle at the negedge; expected operands are queued for the monitor.
    task automatic cyc(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic ld);
        @(negedge clk);
        reg_write  = we;
        write_reg  = wr;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        load_ab    = ld;
        if (ld) exp_q.push_back({model_val(r1, we, wr, wd), model_val(r2, we, wr, wd)});
        if (we && wr != 5'd0) model[wr] = wd;
    endtask

    // Monitor: each captured load is compared just after the edge that performed it.
    initial begin
        logic        ld_s;
        logic [63:0] e;
        forever begin
            @(posedge clk);
            ld_s = load_ab && !reset;
            #1;
            if (ld_s) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: capture with no expected entry");
                end else begin
                    e = exp_q.pop_front();
                    chk("read_data1", read_data1, e[63:32]);
                    chk("read_data2", read_data2, e[31:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0; load_ab = 1'b0;
        model_reset();
        #12;
        chk("reset_rd1", read_data1, 32'h0);
        chk("reset_rd2", read_data2, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-cycle after writes to 5 and 29
        cyc(1'b1, 5'd5,  32'h0000_0011, 5'd0, 5'd0, 1'b0);
        cyc(1'b1, 5'd29, 32'h0000_0022, 5'd0, 5'd0, 1'b0);
        cyc(1'b0, 5'd0,  32'h0,         5'd29, 5'd5, 1'b1);
        @(negedge clk);
        load_ab = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_rd1", read_data1, 32'h0);
        chk("async_reset_rd2", read_data2, 32'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b0, 5'd0, 32'h0, 5'd29, 5'd5, 1'b1);
        cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        chk("sp_after_reset", read_data1, 32'd227);

        // Write/read and hold
        cyc(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0);
        cyc(1'b0, 5'd0, 32'h0,         5'd8, 5'd0, 1'b1);
        cyc(1'b1, 5'd8, 32'h0BAD_0BAD, 5'd8, 5'd8, 1'b0);
        cyc(1'b0, 5'd0, 32'h0,         5'd8, 5'd8, 1'b0);
        chk("hold_rd1", read_data1, 32'hDEAD_BEEF);
        cyc(1'b0, 5'd0, 32'h0, 5'd8, 5'd0, 1'b1);

        // Register 0 write with same-edge read of 0, then later read
        cyc(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, 1'b1);
        cyc(1'b0, 5'd0, 32'h0,         5'd0, 5'd0, 1'b1);

        // Same-edge bypass on $ra
        cyc(1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd31, 1'b1);
        cyc(1'b0, 5'd0,  32'h0,         5'd31, 5'd31, 1'b1);

        // Reset asserted before the edge of a write and held through it
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd10; write_data = 32'h55; load_ab = 1'b0;
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        reg_write = 1'b0;
        model_reset();
        cyc(1'b0, 5'd0, 32'h0, 5'd10, 5'd29, 1'b1);

        // Sweep: regs[i] = i*3, then read pairs (i, 31-i)
        for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'(i * 3), 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 32; i++) cyc(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1);
        cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
        cyc(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
